// File: rtl/bitcell_array_mem_pkg.sv
// Shared definitions for the bitcell array register file.
// Holds the FSM state encoding, the r_w access polarity and the default geometry.
package bitcell_array_mem_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;
    localparam int unsigned DEFAULT_DEPTH = 16;

    // r_w polarity inherited from the single bitcell
    localparam logic R_W_WRITE = 1'b1;
    localparam logic R_W_READ  = 1'b0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_e;

endpackage : bitcell_array_mem_pkg

// File: rtl/bitcell_array_mem_if.sv
// Access bus of the bitcell array register file.
// master: drives sel, r_w, addr, in, clr; receives out, out_valid, ready.
// slave : the array side of the same signals.
interface bitcell_array_mem_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) ();

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              sel;
    logic              r_w;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  in;
    logic              clr;
    logic [WIDTH-1:0]  out;
    logic              out_valid;
    logic              ready;

    modport master (
        output sel, r_w, addr, in, clr,
        input  out, out_valid, ready
    );

    modport slave (
        input  sel, r_w, addr, in, clr,
        output out, out_valid, ready
    );

endinterface : bitcell_array_mem_if

// File: rtl/bitcell_array_mem_bitcell_row.sv
// One WIDTH-bit storage row of the array; loads d_i on a clock edge with we_i high.
// Ports: clk, we_i (write enable), d_i (write data), q_o (stored word).
// No reset: contents are initialised by the clear sweep of the parent.
module bitcell_row #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    // Row storage
    always_ff @(posedge clk) begin
        if (we_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : bitcell_row

// File: rtl/bitcell_array_mem.sv
// DEPTH x WIDTH single-port register file built from bitcell rows.
// Ports: clk, rst_n (async active-low), bus (slave side of bitcell_array_mem_if:
// sel/r_w/addr/in/clr in, registered out/out_valid/ready out).
// After reset or a clr request a sweep writes INIT_VAL to every row, one per
// cycle; accesses are only accepted in IDLE (ready high).
module bitcell_array_mem
    import bitcell_array_mem_pkg::*;
#(
    parameter int unsigned      WIDTH    = DEFAULT_WIDTH,
    parameter int unsigned      DEPTH    = DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    bitcell_array_mem_if.slave  bus
);

    localparam int unsigned ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0]  out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic              wr_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [WIDTH-1:0]  wr_data_c;
    logic              addr_ok_c;
    logic [WIDTH-1:0]  rd_data_c;

    logic [WIDTH-1:0]  row_q [DEPTH];

    // Address range check and read mux; out-of-range reads return zero
    assign addr_ok_c = (32'(bus.addr) < DEPTH);
    assign rd_data_c = addr_ok_c ? row_q[bus.addr] : '0;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            ptr_q       <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state, write port and output register control
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        wr_en_c     = 1'b0;
        wr_addr_c   = bus.addr;
        wr_data_c   = bus.in;

        unique case (state_q)
            ST_CLEAR: begin
                wr_en_c   = 1'b1;
                wr_addr_c = ptr_q;
                wr_data_c = INIT_VAL;
                if (bus.clr) begin
                    // A new clear request restarts the sweep from row 0
                    ptr_d = '0;
                    out_d = '0;
                end else if (ptr_q == ADDR_W'(DEPTH - 1)) begin
                    ptr_d   = '0;
                    state_d = ST_IDLE;
                end else begin
                    ptr_d = ptr_q + ADDR_W'(1);
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    // clr wins over any access sampled on the same edge
                    state_d = ST_CLEAR;
                    ptr_d   = '0;
                    out_d   = '0;
                end else if (bus.sel) begin
                    if (bus.r_w == R_W_WRITE) begin
                        wr_en_c = addr_ok_c;
                    end else begin
                        out_d       = rd_data_c;
                        out_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
                ptr_d   = '0;
            end
        endcase
    end

    // Row array with one-hot write decode
    for (genvar r = 0; r < DEPTH; r++) begin : g_row
        bitcell_row #(
            .WIDTH (WIDTH)
        ) u_row (
            .clk  (clk),
            .we_i (wr_en_c && (wr_addr_c == ADDR_W'(r))),
            .d_i  (wr_data_c),
            .q_o  (row_q[r])
        );
    end

    assign bus.out       = out_q;
    assign bus.out_valid = out_valid_q;
    assign bus.ready     = (state_q == ST_IDLE);

endmodule : bitcell_array_mem

// File: tb/tb_bitcell_array_mem.sv
// Directed bench for bitcell_array_mem: a DEPTH=16 instance for the main
// sequences and a DEPTH=12 instance for out-of-range addressing.
module tb_bitcell_array_mem;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    bitcell_array_mem_if #(.WIDTH(8), .DEPTH(16)) ifa ();
    bitcell_array_mem_if #(.WIDTH(8), .DEPTH(12)) ifb ();

    bitcell_array_mem #(
        .WIDTH    (8),
        .DEPTH    (16),
        .INIT_VAL (8'h00)
    ) u_dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa)
    );

    bitcell_array_mem #(
        .WIDTH    (8),
        .DEPTH    (12),
        .INIT_VAL (8'h00)
    ) u_dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until ready rises, bounded
    task automatic wait_ready_a(input string tag, input int exp_cycles);
        int n;
        n = 0;
        while (ifa.ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'(exp_cycles));
    endtask

    task automatic wr_a(input logic [3:0] a, input logic [7:0] d);
        ifa.sel = 1'b1; ifa.r_w = 1'b1; ifa.addr = a; ifa.in = d;
        tick();
        ifa.sel = 1'b0;
    endtask

    task automatic rd_a(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ifa.sel = 1'b1; ifa.r_w = 1'b0; ifa.addr = a;
        tick();
        ifa.sel = 1'b0;
        check({tag, "_data"}, 32'(ifa.out), 32'(exp));
        check({tag, "_vld"}, 32'(ifa.out_valid), 32'd1);
    endtask

    task automatic wr_b(input logic [3:0] a, input logic [7:0] d);
        ifb.sel = 1'b1; ifb.r_w = 1'b1; ifb.addr = a; ifb.in = d;
        tick();
        ifb.sel = 1'b0;
    endtask

    task automatic rd_b(input string tag, input logic [3:0] a, input logic [7:0] exp);
        ifb.sel = 1'b1; ifb.r_w = 1'b0; ifb.addr = a;
        tick();
        ifb.sel = 1'b0;
        check({tag, "_data"}, 32'(ifb.out), 32'(exp));
        check({tag, "_vld"}, 32'(ifb.out_valid), 32'd1);
    endtask

    initial begin
        int n;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        ifa.sel = 1'b0; ifa.r_w = 1'b0; ifa.addr = '0; ifa.in = '0; ifa.clr = 1'b0;
        ifb.sel = 1'b0; ifb.r_w = 1'b0; ifb.addr = '0; ifb.in = '0; ifb.clr = 1'b0;

        // 1: reset values, 16-cycle sweep, read of a cleared row
        tick();
        tick();
        check("rst_ready", 32'(ifa.ready), 32'd0);
        check("rst_out", 32'(ifa.out), 32'd0);
        check("rst_vld", 32'(ifa.out_valid), 32'd0);
        rst_n = 1'b1;
        wait_ready_a("sweep_len_rst", 16);
        rd_a("rd5_init", 4'd5, 8'h00);
        tick();
        check("rd5_vld_drop", 32'(ifa.out_valid), 32'd0);

        // 2: read-after-write, output holds afterwards
        wr_a(4'd3, 8'hA5);
        check("wr_no_vld", 32'(ifa.out_valid), 32'd0);
        rd_a("raw3", 4'd3, 8'hA5);
        for (int i = 0; i < 5; i++) tick();
        check("hold_out", 32'(ifa.out), 32'hA5);
        check("hold_vld", 32'(ifa.out_valid), 32'd0);

        // 3: data captured at write edge; sel=0 write ignored
        wr_a(4'd15, 8'h3C);
        ifa.in = 8'hFF; tick();
        ifa.in = 8'h00; tick();
        rd_a("rd15", 4'd15, 8'h3C);
        wr_a(4'd7, 8'h11);
        ifa.sel = 1'b0; ifa.r_w = 1'b1; ifa.addr = 4'd7; ifa.in = 8'h77;
        tick();
        check("nosel_vld", 32'(ifa.out_valid), 32'd0);
        check("nosel_out", 32'(ifa.out), 32'h3C);
        rd_a("rd7_nosel", 4'd7, 8'h11);

        // 4: out-of-range access on the DEPTH=12 instance
        n = 0;
        while (ifb.ready !== 1'b1 && n < 100) begin tick(); n++; end
        check("b_ready", 32'(ifb.ready), 32'd1);
        for (int i = 0; i < 12; i++) wr_b(4'(i), 8'(8'h10 + i));
        rd_b("b_rd4", 4'd4, 8'h14);
        rd_b("b_rd13", 4'd13, 8'h00);
        wr_b(4'd13, 8'hEE);
        for (int i = 0; i < 12; i++) rd_b($sformatf("b_row%0d", i), 4'(i), 8'(8'h10 + i));
        rd_b("b_rd13_again", 4'd13, 8'h00);

        // 5: clr with a simultaneous write
        rd_a("pre_clr", 4'd3, 8'hA5);
        ifa.sel = 1'b1; ifa.r_w = 1'b1; ifa.addr = 4'd2; ifa.in = 8'hFF; ifa.clr = 1'b1;
        tick();
        ifa.sel = 1'b0; ifa.clr = 1'b0;
        check("clr_out", 32'(ifa.out), 32'd0);
        check("clr_ready", 32'(ifa.ready), 32'd0);
        check("clr_vld", 32'(ifa.out_valid), 32'd0);
        wait_ready_a("sweep_len_clr", 16);
        for (int i = 0; i < 16; i++) rd_a($sformatf("clr_row%0d", i), 4'(i), 8'h00);

        // 6a: reset during an active read strobe
        wr_a(4'd9, 8'h5A);
        rd_a("rd9", 4'd9, 8'h5A);
        rst_n = 1'b0;
        #1;
        check("mid_rst_out", 32'(ifa.out), 32'd0);
        check("mid_rst_vld", 32'(ifa.out_valid), 32'd0);
        check("mid_rst_ready", 32'(ifa.ready), 32'd0);
        rst_n = 1'b1;
        wait_ready_a("sweep_len_rst2", 16);

        // 6b: reset at sweep cycle 6
        ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        rst_n = 1'b0;
        #1;
        check("sweep_rst_ready", 32'(ifa.ready), 32'd0);
        check("sweep_rst_out", 32'(ifa.out), 32'd0);
        rst_n = 1'b1;
        wait_ready_a("sweep_len_rst3", 16);

        // 6c: clr during a sweep restarts it
        ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        ifa.clr = 1'b1; tick(); ifa.clr = 1'b0;
        check("reclr_out", 32'(ifa.out), 32'd0);
        wait_ready_a("sweep_len_reclr", 16);
        rd_a("rd9_cleared", 4'd9, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_bitcell_array_mem

// File: doc/bitcell_array_mem.md
Name: bitcell_array_mem

Overview:
Parametrised successor to the single NAND-latch bitcell: a DEPTH x WIDTH single-port storage array built from clocked bitcell rows.
- Keeps the bitcell's sel / r_w / in / out access semantics.
- Adds word addressing, registered read data with a valid strobe, and a ready handshake.
- Adds an automatic clear sequencer that runs after reset or on request.
- Sits as a small local register file beside the datapath blocks.

Parameters:
WIDTH, 8, bits per word.
DEPTH, 16, number of words; any value >= 2, not required to be a power of two.
ADDR_W, $clog2(DEPTH), address width; derived, not overridden.
INIT_VAL, 0, WIDTH-bit value written to every row by the clear sequence.

Ports:
clk  input  1  clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
sel  input  1  access request; sampled only when ready=1.
r_w  input  1  1 = write, 0 = read (same polarity as the bitcell).
addr  input  ADDR_W  word address.
in  input  WIDTH  write data.
clr  input  1  clear request; one-cycle pulse is sufficient.
out  output  WIDTH  registered read data; holds its last value between reads.
out_valid  output  1  one-cycle strobe, high in the cycle out is updated by a read.
ready  output  1  high in IDLE; accesses are accepted only when high.

Behaviour:
- Reset (rst_n=0, async):
  - State = CLEAR, clear pointer = 0.
  - out = 0, out_valid = 0, ready = 0.
  - Array contents are not reset directly; the clear sweep overwrites them.
- States: CLEAR, IDLE.
- CLEAR:
  - Each cycle, write INIT_VAL to row[ptr] and increment ptr.
  - After row DEPTH-1 is written, go to IDLE.
  - Sweep takes exactly DEPTH cycles after rst_n deasserts; ready rises at the start of cycle DEPTH.
- IDLE: ready = 1.
- Write (sel=1, r_w=1, ready=1 at an edge):
  - row[addr] takes in at that edge.
  - out is unchanged and out_valid = 0.
- Read (sel=1, r_w=0, ready=1 at an edge):
  - At that edge out is loaded with row[addr] and out_valid = 1 for one cycle (latency 1).
  - out then holds until the next read, clear request or reset.
- Read-after-write: a read in the cycle after a write to the same address returns the new data.
- sel=0 or ready=0: no array change, out holds, out_valid = 0. Requests while ready=0 are dropped, not queued.
- Out-of-range address (addr >= DEPTH):
  - Write is dropped.
  - Read loads out = 0 and still pulses out_valid.
- clr sampled high in IDLE:
  - Go to CLEAR at that edge, ptr = 0, ready = 0 from the next cycle.
  - out is cleared to 0.
  - clr has priority over an access sampled at the same edge; that access is dropped.
- clr high during CLEAR: ptr restarts at 0 and the full DEPTH-cycle sweep repeats.
- rst_n asserted mid-sweep or mid-access: immediate return to the reset values; the sweep restarts from row 0.
- Single port only; simultaneous read and write cannot occur.

Decomposition:
- Shared package/header holds:
  - state encoding (ST_CLEAR = 1'b0, ST_IDLE = 1'b1);
  - the R_W_WRITE = 1 / R_W_READ = 0 constants;
  - the default WIDTH and DEPTH.
- Sub-module bitcell_row:
  - one WIDTH-bit row with write-enable and data input, no reset;
  - instantiated DEPTH times via generate.
- The top level contains the address decode, read mux, output register and clear FSM.

Test Plan (WIDTH=8, DEPTH=16, INIT_VAL=0):
1. Release rst_n, hold sel=0 -> ready=0 for exactly 16 cycles then 1; read addr 5 -> out=8'h00, out_valid one cycle.
2. Write 8'hA5 to addr 3, then read addr 3 on the next cycle -> out=8'hA5 one cycle after the read edge; out holds 8'hA5 with out_valid=0 after 5 idle cycles.
3. Write 8'h3C to addr 15 with in toggling afterwards, read addr 15 -> 8'h3C; write to addr 7 with sel=0 -> a later read of addr 7 returns the prior value.
4. Read with addr beyond DEPTH (use DEPTH=12, addr=13) -> out=0 with out_valid; a write there leaves every other row unchanged.
5. With rows loaded, pulse clr together with a write of 8'hFF to addr 2 -> write dropped, ready low 16 cycles, out=0, all rows read back 8'h00.
6. Assert rst_n=0 at sweep cycle 6, release it; also pulse clr mid-sweep -> out=0, out_valid=0 immediately on reset, and each case needs a full 16 cycles before ready=1.
